// File: rtl/pulse_count_pkg.sv
// Shared constants and helpers for the multi-channel pulse counter.
package pulse_count_pkg;

  parameter int unsigned CntWDefault = 16;
  localparam int unsigned TimerW = 8;

  // LSB position of channel ch inside a packed count bus
  function automatic int unsigned count_lsb(input int unsigned ch, input int unsigned cnt_w);
    return ch * cnt_w;
  endfunction

endpackage

// File: rtl/coinc_window.sv
// Coincidence window: one down-timer per channel of the pair and the event decision.
module coinc_window
  import pulse_count_pkg::*;
#(
  parameter int unsigned COINC_WIN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic edge_a_i,
  input  logic edge_b_i,
  output logic coinc_event_o
);

  localparam logic [TimerW-1:0] WinLoad = TimerW'(COINC_WIN);

  logic [TimerW-1:0] timer_a_q, timer_a_d;
  logic [TimerW-1:0] timer_b_q, timer_b_d;

  always_comb begin
    coinc_event_o = (edge_a_i & edge_b_i) |
                    (edge_a_i & (timer_b_q != '0)) |
                    (edge_b_i & (timer_a_q != '0));

    timer_a_d = timer_a_q;
    timer_b_d = timer_b_q;
    // A consumed pairing clears both windows, even over a same-cycle load
    if (coinc_event_o) begin
      timer_a_d = '0;
      timer_b_d = '0;
    end else begin
      if (edge_a_i) begin
        timer_a_d = WinLoad;
      end else if (timer_a_q != '0) begin
        timer_a_d = timer_a_q - 1'b1;
      end
      if (edge_b_i) begin
        timer_b_d = WinLoad;
      end else if (timer_b_q != '0) begin
        timer_b_d = timer_b_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_a_q <= '0;
      timer_b_q <= '0;
    end else begin
      timer_a_q <= timer_a_d;
      timer_b_q <= timer_b_d;
    end
  end

endmodule

// File: rtl/multi_channel_pulse_counter.sv
// Per-channel rising-edge counters plus a windowed A/B coincidence counter, latched per batch.
// Define COUNT_SATURATE_EN to make live counters stick at all-ones instead of wrapping.
module multi_channel_pulse_counter
  import pulse_count_pkg::*;
#(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CNT_W     = CntWDefault,
  parameter int unsigned COINC_A   = 0,
  parameter int unsigned COINC_B   = 1,
  parameter int unsigned COINC_WIN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       raw_pulses,
  input  logic                  batch_done,
  output logic [N_CH*CNT_W-1:0] reg_count,
  output logic [CNT_W-1:0]      reg_coinc,
  output logic                  count_valid,
  output logic [N_CH:0]         overflow
);

  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] edges;
  logic            coinc_event;

  // Index N_CH is the coincidence counter; the rest are channels
  logic [N_CH:0]            inc;
  logic [N_CH:0][CNT_W-1:0] cnt_next;
  logic [N_CH:0]            ovf_next;

  logic [N_CH*CNT_W-1:0] reg_count_q;
  logic [CNT_W-1:0]      reg_coinc_q;
  logic                  count_valid_q;
  logic [N_CH:0]         overflow_q;

  assign edges = raw_pulses & ~prev_q;
  assign inc   = {coinc_event, edges};

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= raw_pulses;
    end
  end

  coinc_window #(
    .COINC_WIN(COINC_WIN)
  ) u_coinc_window (
    .clk_i        (clk),
    .rst_i        (rst),
    .edge_a_i     (edges[COINC_A]),
    .edge_b_i     (edges[COINC_B]),
    .coinc_event_o(coinc_event)
  );

  for (genvar i = 0; i <= N_CH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf_live_q;
    logic             full;

    assign full = &cnt_q;

    always_comb begin
      cnt_inc = cnt_q;
      if (inc[i]) begin
`ifdef COUNT_SATURATE_EN
        cnt_inc = full ? cnt_q : cnt_q + 1'b1;
`else
        cnt_inc = cnt_q + 1'b1;
`endif
      end
    end

    // Values presented to the output latch include this cycle's increment
    assign cnt_next[i] = cnt_inc;
    assign ovf_next[i] = ovf_live_q | (inc[i] & full);

    always_ff @(posedge clk) begin
      if (rst || batch_done) begin
        cnt_q      <= '0;
        ovf_live_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_inc;
        ovf_live_q <= ovf_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_count_q   <= '0;
      reg_coinc_q   <= '0;
      overflow_q    <= '0;
      count_valid_q <= 1'b0;
    end else begin
      count_valid_q <= batch_done;
      if (batch_done) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          reg_count_q[count_lsb(i, CNT_W) +: CNT_W] <= cnt_next[i];
        end
        reg_coinc_q <= cnt_next[N_CH];
        overflow_q  <= ovf_next;
      end
    end
  end

  assign reg_count   = reg_count_q;
  assign reg_coinc   = reg_coinc_q;
  assign count_valid = count_valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_multi_channel_pulse_counter.sv
// Randomized and directed bench for multi_channel_pulse_counter against a behavioural model.
module tb_multi_channel_pulse_counter;
  import pulse_count_pkg::*;

  localparam int NCh    = 4;
  localparam int CntW   = 4;
  localparam int Win    = 3;
  localparam int CntMax = (1 << CntW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCh-1:0]       raw_pulses;
  logic                 batch_done;
  logic [NCh*CntW-1:0]  reg_count;
  logic [CntW-1:0]      reg_coinc;
  logic                 count_valid;
  logic [NCh:0]         overflow;

  multi_channel_pulse_counter #(
    .N_CH     (NCh),
    .CNT_W    (CntW),
    .COINC_A  (0),
    .COINC_B  (1),
    .COINC_WIN(Win)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_pulses (raw_pulses),
    .batch_done (batch_done),
    .reg_count  (reg_count),
    .reg_coinc  (reg_coinc),
    .count_valid(count_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: true (unbounded) batch totals, and the time of the last unpaired A/B edge
  bit prev_m [NCh];
  int tot    [NCh+1];
  bit ua_v, ub_v;
  int ua_t, ub_t;
  int t = 0;
  int exp_cnt [NCh+1];
  bit exp_ovf [NCh+1];
  bit exp_valid;

  function automatic int shown(input int n);
`ifdef COUNT_SATURATE_EN
    return (n > CntMax) ? CntMax : n;
`else
    return n % (CntMax + 1);
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, req);
    end
  endtask

  task automatic model_step(input logic [NCh-1:0] p, input bit bd, input bit r);
    bit e [NCh];
    bit ev;
    if (r) begin
      for (int i = 0; i < NCh; i++) prev_m[i] = 1'b0;
      for (int i = 0; i <= NCh; i++) begin
        tot[i] = 0;
        exp_cnt[i] = 0;
        exp_ovf[i] = 1'b0;
      end
      ua_v = 1'b0;
      ub_v = 1'b0;
      exp_valid = 1'b0;
    end else begin
      for (int i = 0; i < NCh; i++) begin
        e[i] = p[i] && !prev_m[i];
        prev_m[i] = p[i];
        if (e[i]) tot[i]++;
      end
      ev = (e[0] && e[1]) ||
           (e[0] && ub_v && (t - ub_t) <= Win) ||
           (e[1] && ua_v && (t - ua_t) <= Win);
      if (ev) begin
        tot[NCh]++;
        ua_v = 1'b0;
        ub_v = 1'b0;
      end else begin
        if (e[0]) begin ua_v = 1'b1; ua_t = t; end
        if (e[1]) begin ub_v = 1'b1; ub_t = t; end
      end
      exp_valid = bd;
      if (bd) begin
        for (int i = 0; i <= NCh; i++) begin
          exp_cnt[i] = shown(tot[i]);
          exp_ovf[i] = tot[i] > CntMax;
          tot[i] = 0;
        end
      end
    end
    t++;
  endtask

  // Drive one clock's worth of inputs, advance the model, then compare every output
  task automatic cycle(input logic [NCh-1:0] p, input bit bd, input bit r);
    raw_pulses = p;
    batch_done = bd;
    rst        = r;
    model_step(p, bd, r);
    @(posedge clk);
    #1;
    for (int i = 0; i < NCh; i++) begin
      check($sformatf("reg_count[%0d]", i), int'(reg_count[count_lsb(i, CntW) +: CntW]),
            exp_cnt[i]);
      check($sformatf("overflow[%0d]", i), int'(overflow[i]), int'(exp_ovf[i]));
    end
    check("reg_coinc", int'(reg_coinc), exp_cnt[NCh]);
    check("overflow[coinc]", int'(overflow[NCh]), int'(exp_ovf[NCh]));
    check("count_valid", int'(count_valid), int'(exp_valid));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0);
  endtask

  task automatic coinc_case(input string name, input int gap, input int req);
    idle(6);
    if (gap == 0) begin
      cycle(4'b0011, 1'b0, 1'b0);
    end else begin
      cycle(4'b0001, 1'b0, 1'b0);
      idle(gap - 1);
      cycle(4'b0010, 1'b0, 1'b0);
    end
    idle(6);
    cycle('0, 1'b1, 1'b0);
    check(name, int'(reg_coinc), req);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) cycle('0, 1'b0, 1'b1);
    check("reset reg_count", int'(reg_count), 0);
    check("reset valid", int'(count_valid), 0);
    idle(2);

    // Basic count: ch0 every 10 cycles over 100 cycles
    for (int i = 0; i < 100; i++) cycle((i % 10 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    check("basic ch0", int'(reg_count[0 +: CntW]), 10);
    check("basic ch1..3", int'(reg_count[CntW +: 3*CntW]), 0);
    check("basic valid", int'(count_valid), 1);
    idle(1);
    check("basic valid drop", int'(count_valid), 0);

    // Held level counts once
    for (int i = 0; i < 20; i++) cycle(4'b0010, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    check("held ch1", int'(reg_count[CntW +: CntW]), 1);

    // Coincidence window
    coinc_case("coinc gap3", 3, 1);
    coinc_case("coinc gap4", 4, 0);
    coinc_case("coinc same", 0, 1);
    idle(6);
    cycle(4'b0001, 1'b0, 1'b0);
    idle(1);
    cycle(4'b0010, 1'b0, 1'b0);
    idle(1);
    cycle(4'b0010, 1'b0, 1'b0);
    idle(6);
    cycle('0, 1'b1, 1'b0);
    check("coinc ABB", int'(reg_coinc), 1);

    // Boundary: same-cycle edge joins the closing batch, then back-to-back close
    idle(3);
    cycle(4'b0100, 1'b1, 1'b0);
    check("boundary ch2", int'(reg_count[2*CntW +: CntW]), 1);
    cycle('0, 1'b1, 1'b0);
    check("b2b ch2", int'(reg_count[2*CntW +: CntW]), 0);
    check("b2b valid", int'(count_valid), 1);

    // Overflow: 17 edges on a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      cycle(4'b1000, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);
    end
    cycle('0, 1'b1, 1'b0);
    check("ovf flag ch3", int'(overflow[3]), 1);
`ifdef COUNT_SATURATE_EN
    check("ovf count ch3", int'(reg_count[3*CntW +: CntW]), 15);
`else
    check("ovf count ch3", int'(reg_count[3*CntW +: CntW]), 1);
`endif
    idle(2);

    // Reset mid-batch, asserted together with batch_done
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);
    end
    cycle('0, 1'b1, 1'b1);
    check("rst valid", int'(count_valid), 0);
    check("rst overflow", int'(overflow), 0);
    idle(1);
    for (int i = 0; i < 2; i++) begin
      cycle(4'b0001, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b0);
    end
    cycle('0, 1'b1, 1'b0);
    check("post-rst ch0", int'(reg_count[0 +: CntW]), 2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [NCh-1:0] p;
      for (int i = 0; i < NCh; i++) p[i] = ($urandom_range(0, 2) == 0);
      cycle(p, ($urandom_range(0, 24) == 0), ($urandom_range(0, 399) == 0));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_pulse_counter.md
# multi_channel_pulse_counter

- Counts rising edges on `N_CH` pulse channels over batches delimited by `batch_done`.
- Counts coincidences between two selected channels that fall within a programmable cycle window.
- Latches all totals into output registers at each batch boundary.
- Sits after the input synchronisers and feeds the readout/UART block; generalised successor of `count_pulses`.

## Interface
Parameters:
- `N_CH`, 4: number of pulse channels (≥2).
- `CNT_W`, 16: counter width for per-channel and coincidence counts.
- `COINC_A`, 0: first channel of the coincidence pair.
- `COINC_B`, 1: second channel of the coincidence pair (≠`COINC_A`).
- `COINC_WIN`, 3: coincidence window in clk cycles (1..255).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `raw_pulses` in `N_CH`: pulse inputs, already synchronous to `clk`.
- `batch_done` in 1: one-cycle strobe that closes the current batch.
- `reg_count` out `N_CH*CNT_W`: latched per-channel counts; channel i at bits `[i*CNT_W +: CNT_W]`.
- `reg_coinc` out `CNT_W`: latched coincidence count.
- `count_valid` out 1: one-cycle strobe, high the cycle after latching.
- `overflow` out `N_CH+1`: latched per-batch overflow flags; bit `N_CH` is the coincidence counter.

## Operation
- **Edge detect:** `prev` register per channel, reset 0. `edge[i] = raw_pulses[i] & ~prev[i]`. A level held high counts once.
- **Live counters:** per channel and coincidence, reset 0. Increment on edge or coincidence event.
- **Overflow:** a live overflow flag is set when an increment occurs while the counter is all-ones. The flag is sticky until the batch closes.
- **Coincidence windows:**
  - Each of A and B has an 8-bit down-timer, reset 0.
  - An edge on a channel loads its timer with `COINC_WIN`; otherwise the timer decrements while nonzero.
  - A coincidence event occurs when:
    - `edge[A] & edge[B]` in the same cycle; or
    - `edge[A]` while `timer_B != 0`; or
    - `edge[B]` while `timer_A != 0`.
  - On a coincidence event, both timers are cleared that cycle, overriding the load. One event is counted per pairing; no double counting.
- **Batch close** (`batch_done` high at edge k):
  - `reg_count`/`reg_coinc`/`overflow` get the live values plus any increment occurring at edge k. Same-cycle pulses belong to the closing batch.
  - Live counters and live flags clear to 0.
  - `count_valid` = 1 for exactly one cycle.
- Coincidence timers and `prev` are not affected by `batch_done`. A pairing straddling a boundary is counted in the batch where the second edge lands.
- Back-to-back `batch_done`: the second latches zero counts (plus same-cycle edges) and pulses `count_valid` again.

## Timing
- **Reset values:** `reg_count`=0, `reg_coinc`=0, `overflow`=0, `count_valid`=0. All internal counters, timers and `prev` are 0.
- **`rst` with `batch_done`:** `rst` wins. No latch, `count_valid` stays 0.
- **Count latency:** an edge sampled at edge k is in the live count after edge k.
- **Batch latency:** `batch_done` at edge k gives new outputs and `count_valid` after edge k. Outputs hold until the next batch close or reset.
- **Window:** an edge on B is coincident with an earlier A edge if it arrives 1..`COINC_WIN` cycles later.
- No backpressure; the consumer must sample on `count_valid`.

## Configuration
- `COUNT_SATURATE_EN`: live counters stick at all-ones on overflow.
- Without it, counters wrap to 0.
- The overflow flag behaves identically in both builds.

## Structure
- Package `pulse_count_pkg`:
  - `CNT_W` default;
  - timer width constant (8);
  - count-slice helper function.
- Sub-module `coinc_window`: timer pair plus coincidence event logic. The top instantiates per-channel edge/counter logic by generate loop.

## Test plan
- **Basic count:** `N_CH`=4; ch0 pulses every 10 cycles for 100 cycles, then `batch_done` → `reg_count[0]`=10, others 0, `count_valid` one cycle.
- **Held level:** ch1 held high 20 cycles → count 1.
- **Coincidence window** (`COINC_WIN`=3):
  - A then B 3 cycles later → `reg_coinc`=1.
  - A then B 4 cycles later → 0.
  - A and B same cycle → 1.
  - A, B, B within window → 1.
- **Boundary:** edge on ch2 in the same cycle as `batch_done` → counted in the closing batch. The next batch starts at 0.
- **Overflow** (`CNT_W`=4, 17 edges): overflow bit set. Count is 15 with `COUNT_SATURATE_EN` defined, 1 without.
- **Reset mid-batch:** 5 edges then `rst` → outputs 0, no `count_valid`. A batch after reset counts only post-reset edges.
